// File: rtl/array_structural.sv
// array_structural: register-file memory built from a write decoder, per-word registers and a read mux
module array_structural #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  write_data,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [WIDTH-1:0]  read_data
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0]       we_vec;
  logic [DEPTH*WIDTH-1:0] words;
  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    logic [WIDTH-1:0] word_d, word_q;
    assign we_vec[k] = write_en && (write_addr == ADDR_W'(k));
    always_comb word_d = we_vec[k] ? write_data : word_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) word_q <= '0;
      else word_q <= word_d;
    assign words[k*WIDTH +: WIDTH] = word_q;
  end
  always_comb read_data = words[read_addr*WIDTH +: WIDTH];
endmodule

// File: tb/tb_array_structural.sv
// tb_array_structural: randomized self-checking bench for array_structural against an array model
module tb_array_structural;
  logic       clk = 0;
  logic       rst_n = 0;
  logic [7:0] write_data = '0;
  logic [1:0] write_addr = '0;
  logic       write_en = 0;
  logic [1:0] read_addr = '0;
  logic [7:0] read_data;
  logic [7:0] mdl [4];
  int checks = 0;
  int errors = 0;

  array_structural #(.WIDTH(8), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .write_data(write_data), .write_addr(write_addr),
    .write_en(write_en), .read_addr(read_addr), .read_data(read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic rd(input string tag, input int a);
    read_addr = 2'(a);
    #1;
    check($sformatf("%s[%0d]", tag, a), read_data, mdl[a]);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 4; a++) rd(tag, a);
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (rst_n && write_en) mdl[write_addr] = write_data;
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    write_en = 1;
    write_addr = 2'(a);
    write_data = d;
    edge_step();
    write_en = 0;
  endtask

  initial begin
    foreach (mdl[i]) mdl[i] = '0;
    #2;
    sweep("reset_init");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) wr(i, 8'(i * 8'h33));
    sweep("fill");
    check("fill_w3_const", mdl[3], 8'h99);
    @(negedge clk);
    write_en = 0;
    write_addr = 2;
    write_data = 8'hFF;
    repeat (3) edge_step();
    sweep("we_off");
    wr(1, 8'hA5);
    sweep("overwrite");
    @(negedge clk);
    read_addr = 3;
    write_en = 1;
    write_addr = 3;
    write_data = 8'h5A;
    #1;
    check("rdw_before", read_data, 8'h99);
    edge_step();
    check("rdw_after", read_data, 8'h5A);
    write_en = 0;
    sweep("comb_read");
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      write_en = 1'($urandom_range(0, 1));
      write_addr = 2'($urandom);
      write_data = 8'($urandom);
      read_addr = 2'($urandom);
      #1;
      check("rand_pre", read_data, mdl[read_addr]);
      edge_step();
      check("rand_post", read_data, mdl[read_addr]);
    end
    write_en = 0;
    wr(2, 8'hC3);
    rd("pre_reset", 2);
    @(negedge clk);
    #2;
    rst_n = 0;
    foreach (mdl[i]) mdl[i] = '0;
    sweep("reset_mid");
    write_en = 1;
    write_addr = 0;
    write_data = 8'h77;
    edge_step();
    sweep("reset_hold");
    @(negedge clk);
    rst_n = 1;
    edge_step();
    write_en = 0;
    sweep("post_release");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
